mux_nch_rr_reg: RTL
===================

Name: mux_nch_rr_reg

Overview:
Parametrised N-channel, WIDTH-bit multiplexer with a registered output stage and valid/ready handshakes on every input and on the output. It supports two selection modes: fixed selection by an external select value, or round-robin arbitration among the valid channels. It is the sequential successor of the combinational 2-bit 2:1 mux and serves as the channel-merge stage feeding downstream lab datapaths.

Parameters:
WIDTH, 2, data width per channel in bits (>=1)
NCH, 4, number of input channels (>=2)
SELW, 2, width of select/channel index (2^SELW >= NCH)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel valid
in_ready  output  NCH  per-channel ready (combinational, one-hot or zero)
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SELW  channel index used in fixed mode
out_data  output  WIDTH  registered selected data
out_chan  output  SELW  registered index of the channel that supplied out_data
out_valid  output  1  output register holds a valid word
out_ready  input  1  downstream accepts the word

Behaviour:
- Reset (reset_n=0, asynchronous): out_valid=0, out_data=0, out_chan=0, rr pointer=0. All in_ready are 0 while reset_n=0.
- load_en = !out_valid || out_ready. The output register loads only when load_en=1.
- grant: combinational choice of at most one channel.
  - Fixed mode: grant=sel when sel<NCH and in_valid[sel]=1. Otherwise there is no grant. sel>=NCH never grants.
  - RR mode: grant is the first channel with in_valid=1, scanning ptr, ptr+1, ..., wrapping modulo NCH. If no channel is valid, there is no grant.
- in_ready[i] = load_en && grant==i. Exactly one in_ready is high when a transfer is possible; otherwise all are 0.
- Input transfer on channel g: in_valid[g] && in_ready[g]. At that edge: out_data<=in_data[g], out_chan<=g, out_valid<=1.
- Output transfer: out_valid && out_ready. If no input is accepted in the same cycle, out_valid<=0 and out_data/out_chan hold their last values.
- Simultaneous output drain and input accept: the new word replaces the old one, out_valid stays 1, and there is no bubble. Sustained throughput is 1 word/cycle with out_ready held at 1.
- Latency: input accept at edge N makes the word visible on out_data from edge N, i.e. one register stage.
- Backpressure: while out_valid=1 and out_ready=0, the output is stable (data, chan, valid unchanged) regardless of in_data, sel or mode changes.
- RR pointer: on every input transfer in RR mode, ptr<=(g+1) mod NCH, with explicit wrap for non-power-of-2 NCH. In fixed mode, ptr holds. Mode switches take effect combinationally in the same cycle, and ptr is retained across switches.
- Fairness: in RR mode with all channels continuously valid and out_ready=1, the grants go 0,1,...,NCH-1,0,...
- Reset asserted mid-operation discards the held word immediately and clears the pointer.
- No X propagation: in_data of unselected channels never affects the outputs.

Test Plan:
- Reset: assert reset_n=0 asynchronously mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately. After release with all in_valid=0 -> out_valid stays 0.
- Fixed mode: mode=0, sel=2, in_data={3,2,1,0}, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100, out_data=2, out_chan=2 every cycle. sel=3 -> out_data=3 after the next edge. sel=2 with in_valid[2]=0 -> in_ready=0 and out_valid drops after one drain.
- Round-robin: mode=1, in_valid=4'b1111, out_ready=1, data = channel index -> out_chan sequence 0,1,2,3,0 on consecutive cycles. in_valid=4'b1010 -> sequence 1,3,1,3.
- Backpressure: hold out_ready=0 with out_valid=1 (out_data=1) for 5 cycles while changing sel/in_data -> out_data=1, out_chan unchanged, in_ready=0. Raise out_ready -> the next word loads in the same cycle with no bubble.
- Wrap with NCH=3, SELW=2: RR over in_valid=3'b111 -> chan 0,1,2,0. Fixed sel=3 -> no grant and in_ready=0.
- Mode switch: in RR with ptr=2, switch to mode=0 for 3 transfers on sel=0, then back to RR with all valid -> the first RR grant is channel 2.

Source files
------------

// File: rtl/mux_nch_rr_reg.sv
// mux_nch_rr_reg
//
// N-channel, WIDTH-bit multiplexer with a single registered output stage and
// valid/ready handshakes on every input and on the output. Channel selection
// is either fixed (external sel) or round-robin among the valid channels.
// A new word may be accepted in the same cycle the held word drains, giving
// 1 word/cycle sustained throughput.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, one-hot or zero)
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode
//   out_data   registered selected data
//   out_chan   registered index of the channel that supplied out_data
//   out_valid  output register holds a valid word
//   out_ready  downstream accepts the word

module mux_nch_rr_reg #(
    parameter int WIDTH = 2,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_chan,
    output logic                   out_valid,
    input  logic                   out_ready
);

    // Every value of a SELW-bit index gets a slot; slots at or above NCH read
    // as "not valid" with zero data, so an out-of-range sel never grants.
    localparam int NPAD = 1 << SELW;

    logic [NPAD-1:0]  valid_pad;
    logic [WIDTH-1:0] data_pad [NPAD];

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;

    logic [SELW-1:0]  cand_idx [NCH];
    logic [NCH-1:0]   cand_vld;
    logic             rr_found;
    logic [SELW-1:0]  rr_idx;
    logic             fix_found;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic             load_en;
    logic             accept;

    genvar gi;

    generate
        for (gi = 0; gi < NPAD; gi++) begin : g_pad
            if (gi < NCH) begin : g_real
                assign valid_pad[gi] = in_valid[gi];
                assign data_pad[gi]  = in_data[gi*WIDTH +: WIDTH];
            end else begin : g_none
                assign valid_pad[gi] = 1'b0;
                assign data_pad[gi]  = '0;
            end
        end
    endgenerate

    // Candidate gi is channel (ptr + gi) mod NCH. The sum is computed one bit
    // wider so the wrap works for non-power-of-2 NCH.
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_rot
            logic [SELW:0] sum;
            assign sum = {1'b0, ptr_q} + (SELW+1)'(gi);
            assign cand_idx[gi] = (sum >= (SELW+1)'(NCH))
                                ? SELW'(sum - (SELW+1)'(NCH))
                                : sum[SELW-1:0];
            assign cand_vld[gi] = valid_pad[cand_idx[gi]];
        end
    endgenerate

    // First valid candidate wins: scan from the far end so the lowest offset
    // from ptr is the last (winning) assignment.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (cand_vld[k]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx[k];
            end
        end
    end

    assign fix_found = (int'(sel) < NCH) && valid_pad[sel];
    assign grant_vld = mode ? rr_found : fix_found;
    assign grant_idx = mode ? rr_idx   : sel;

    assign load_en = !out_valid_q || out_ready;
    // reset_n gates acceptance so no input sees ready while reset is held.
    assign accept  = reset_n && load_en && grant_vld;

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_rdy
            assign in_ready[gi] = accept && (grant_idx == SELW'(gi));
        end
    endgenerate

    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            // Load replaces any word draining this cycle: no bubble.
            out_data_d  = data_pad[grant_idx];
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);
            end
        end else if (out_valid_q && out_ready) begin
            // Drain without refill: data/chan hold their last values.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule
